// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the MMIO I/O controller: region nibble, register offsets, decode helper.
package mmio_io_ctrl_pkg;

    localparam logic [3:0] MMIO_REGION   = 4'h8;

    localparam logic [7:0] OFF_UART_STAT = 8'h00;
    localparam logic [7:0] OFF_UART_RX   = 8'h04;
    localparam logic [7:0] OFF_UART_TX   = 8'h08;
    localparam logic [7:0] OFF_CYCLE     = 8'h10;
    localparam logic [7:0] OFF_INST      = 8'h14;
    localparam logic [7:0] OFF_CNT_CLR   = 8'h18;
    localparam logic [7:0] OFF_BRANCH    = 8'h1C;
    localparam logic [7:0] OFF_BTN_STAT  = 8'h20;
    localparam logic [7:0] OFF_BTN_DATA  = 8'h24;
    localparam logic [7:0] OFF_SWITCHES  = 8'h28;
    localparam logic [7:0] OFF_LEDS      = 8'h30;
    localparam logic [7:0] OFF_MISPRED   = 8'h34;

    function automatic logic mmio_hit(input logic [31:0] addr);
        return addr[31:28] == MMIO_REGION;
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU memory-stage to MMIO controller bus: address, store data, strobes and registered load data.
interface mmio_io_ctrl_if;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;

    modport master (output mmio_addr, mmio_wdata, mmio_we, mmio_re, input  mmio_rdata);
    modport slave  (input  mmio_addr, mmio_wdata, mmio_we, mmio_re, output mmio_rdata);
endinterface

// File: rtl/mmio_io_ctrl_sync_fifo.sv
// Synchronous FIFO with pointer+count bookkeeping; a push at full is accepted only alongside a pop.
module mmio_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller for region 0x8xxx_xxxx: counters, button event FIFO, switches, LEDs, UART bridge.
// Optional branch/mispredict counters at 0x1C/0x34 are enabled with `define MMIO_BRANCH_CNT_EN.
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int unsigned BTN_FIFO_DEPTH = 8,
    parameter int unsigned N_BUTTONS      = 3,
    parameter int unsigned N_SWITCHES     = 2,
    parameter int unsigned N_LEDS         = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_io_ctrl_if.slave         mmio,
    input  logic                  inst_retire,
`ifdef MMIO_BRANCH_CNT_EN
    input  logic                  branch_resolved,
    input  logic                  branch_mispredict,
`endif
    input  logic [N_BUTTONS-1:0]  clean_buttons,
    input  logic [N_SWITCHES-1:0] switches,
    output logic [N_LEDS-1:0]     leds,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_rx_valid,
    output logic                  uart_rx_ready,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready
);
    logic [7:0]           off;
    logic                 rd_en;
    logic                 wr_en;
    logic                 cnt_clr;
    logic                 tx_load;
    logic [31:0]          cycle_cnt, cycle_nxt;
    logic [31:0]          inst_cnt, inst_nxt;
    logic [31:0]          rd_val;
    logic [N_BUTTONS-1:0] btn_prev;
    logic [N_BUTTONS-1:0] btn_rise;
    logic [N_BUTTONS-1:0] btn_head;
    logic                 btn_full;
    logic                 btn_empty;
    logic                 btn_pop;
    logic                 unused_bits;
`ifdef MMIO_BRANCH_CNT_EN
    logic [31:0]          branch_cnt, branch_nxt;
    logic [31:0]          mispred_cnt, mispred_nxt;
`endif

    assign off         = mmio.mmio_addr[7:0];
    assign rd_en       = mmio.mmio_re && mmio_hit(mmio.mmio_addr);
    assign wr_en       = mmio.mmio_we && mmio_hit(mmio.mmio_addr);
    assign cnt_clr     = wr_en && (off == OFF_CNT_CLR);
    assign tx_load     = wr_en && (off == OFF_UART_TX) && uart_tx_ready;
    assign btn_pop     = rd_en && (off == OFF_BTN_DATA);
    assign btn_rise    = clean_buttons & ~btn_prev;
    assign unused_bits = ^{mmio.mmio_addr[27:8], mmio.mmio_wdata[31:8], btn_full};

    // RX handshake completes on the same edge that captures the byte into mmio_rdata.
    assign uart_rx_ready = !rst && rd_en && (off == OFF_UART_RX) && uart_rx_valid;

    // Loads return the post-update count, so a clear wins over a same-cycle increment.
    always_comb begin
        cycle_nxt   = cnt_clr ? '0 : cycle_cnt + 32'd1;
        inst_nxt    = cnt_clr ? '0 : inst_cnt + {31'b0, inst_retire};
`ifdef MMIO_BRANCH_CNT_EN
        branch_nxt  = cnt_clr ? '0 : branch_cnt + {31'b0, branch_resolved};
        mispred_nxt = cnt_clr ? '0 : mispred_cnt + {31'b0, branch_resolved && branch_mispredict};
`endif
    end

    mmio_sync_fifo #(
        .DEPTH (BTN_FIFO_DEPTH),
        .WIDTH (N_BUTTONS)
    ) u_btn_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (|btn_rise),
        .pop   (btn_pop),
        .wdata (btn_rise),
        .rdata (btn_head),
        .full  (btn_full),
        .empty (btn_empty)
    );

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_UART_STAT: rd_val = {30'b0, uart_rx_valid, uart_tx_ready};
            OFF_UART_RX:   rd_val = uart_rx_valid ? {24'b0, uart_rx_data} : '0;
            OFF_CYCLE:     rd_val = cycle_nxt;
            OFF_INST:      rd_val = inst_nxt;
            OFF_BTN_STAT:  rd_val = {31'b0, btn_empty};
            OFF_BTN_DATA:  rd_val = btn_empty ? '0 : 32'(btn_head);
            OFF_SWITCHES:  rd_val = 32'(switches);
`ifdef MMIO_BRANCH_CNT_EN
            OFF_BRANCH:    rd_val = branch_nxt;
            OFF_MISPRED:   rd_val = mispred_nxt;
`endif
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt       <= '0;
            inst_cnt        <= '0;
`ifdef MMIO_BRANCH_CNT_EN
            branch_cnt      <= '0;
            mispred_cnt     <= '0;
`endif
            btn_prev        <= '0;
            mmio.mmio_rdata <= '0;
            leds            <= '0;
            uart_tx_valid   <= 1'b0;
            uart_tx_data    <= '0;
        end else begin
            cycle_cnt <= cycle_nxt;
            inst_cnt  <= inst_nxt;
`ifdef MMIO_BRANCH_CNT_EN
            branch_cnt  <= branch_nxt;
            mispred_cnt <= mispred_nxt;
`endif
            btn_prev <= clean_buttons;
            if (rd_en) mmio.mmio_rdata <= rd_val;
            if (wr_en && (off == OFF_LEDS)) leds <= mmio.mmio_wdata[N_LEDS-1:0];
            if (tx_load) begin
                uart_tx_valid <= 1'b1;
                uart_tx_data  <= mmio.mmio_wdata[7:0];
            end else if (uart_tx_valid && uart_tx_ready) begin
                uart_tx_valid <= 1'b0;
            end
        end
    end
endmodule
